// File: rtl/seq_pkg.sv
// Shared types and sizing for the serial pattern stream controller.
package seq_pkg;

   localparam int WORD_W    = 8;                 // bits per input word
   localparam int PAT_W     = 4;                 // detector pattern width
   localparam int CNT_W     = 4;                 // per-word match count width (max 8)
   localparam int TOT_W     = 16;                // running match total width
   localparam int BIT_CNT_W = $clog2(WORD_W);
   localparam int FILL_W    = $clog2(PAT_W);

   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   // Controller states: accept a word, serialise it, hand out the result.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Input-word and result handshakes of the stream controller.
interface seq_stream_ctrl_if;
   import seq_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [CNT_W-1:0]  m_count;

   // The controller consumes words and produces counts.
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_count
   );

   // The environment produces words and consumes counts.
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_count
   );

endinterface

// File: rtl/seq_det_core.sv
// Serial pattern detector: bit history, fill level, match and overlap handling.
// History survives across words so patterns straddling a word boundary match.
module seq_det_core
   import seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,            // async, active-low
   input  logic             clr,            // sync clear of history
   input  logic             load,           // word acceptance: latch config
   input  logic [PAT_W-1:0] load_pattern,
   input  logic             load_overlap,
   input  logic             bit_valid,      // one serial bit this cycle
   input  logic             bit_in,
   output logic             match
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  pat_q,  pat_d;
   logic              ovl_q,  ovl_d;
   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              hist_clr;

   // Match on the newest bit; a coincident clr cancels it.
   always_comb begin
      match = bit_valid && !clr && (fill_q == FILL_FULL) && ({hist_q, bit_in} == pat_q);
   end

   // Next-state of configuration, history and fill.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      pat_d    = pat_q;
      ovl_d    = ovl_q;
      hist_d   = hist_q;
      fill_d   = fill_q;
      hist_clr = clr;

      if (load) begin
         pat_d = load_pattern;
         ovl_d = load_overlap;
         // A new pattern must not match against bits gathered for the old one.
         if (load_pattern != pat_q) hist_clr = 1'b1;
      end

      if (bit_valid && !clr) begin
         if (match && !ovl_q) begin
            hist_clr = 1'b1;
         end else begin
            hist_d = {hist_q[PAT_W-3:0], bit_in};
            if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
         end
      end

      if (hist_clr) begin
         hist_d = '0;
         fill_d = '0;
      end
   end

   // Detector state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q  <= '0;
         ovl_q  <= 1'b0;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         pat_q  <= pat_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Stream controller: accepts 8-bit words, feeds them LSB first into the
// serial detector, and reports the number of matches found in each word.
module seq_stream_ctrl
   import seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,          // async, active-low
   input  logic               clr,
   input  logic [PAT_W-1:0]   cfg_pattern,
   input  logic               cfg_overlap,
   seq_stream_ctrl_if.slave   bus,
   output logic [TOT_W-1:0]   det_total,
   output logic               busy
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

   state_e                 state_q,     state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
   logic [CNT_W-1:0]       word_cnt_q,  word_cnt_d;
   logic [WORD_W-1:0]      data_q,      data_d;
   logic [TOT_W-1:0]       det_total_q, det_total_d;

   logic s_ready;
   logic m_valid;
   logic det_load;
   logic det_bit_valid;
   logic det_bit;
   logic det_match;

   assign det_bit = data_q[bit_cnt_q];

   seq_det_core u_det (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .load         (det_load),
      .load_pattern (cfg_pattern),
      .load_overlap (cfg_overlap),
      .bit_valid    (det_bit_valid),
      .bit_in       (det_bit),
      .match        (det_match)
   );

   // FSM next-state, word counters and handshake outputs.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      data_d        = data_q;
      det_load      = 1'b0;
      det_bit_valid = 1'b0;
      s_ready       = 1'b0;
      m_valid       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (bus.s_valid) begin
               data_d     = bus.s_data;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               det_load   = 1'b1;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            det_bit_valid = 1'b1;
            bit_cnt_d     = bit_cnt_q + BIT_CNT_W'(1);
            if (det_match) word_cnt_d = word_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) state_d = ST_REPORT;
         end
         ST_REPORT: begin
            m_valid = 1'b1;
            if (bus.m_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Saturating total of matches; clr takes priority over a coincident match.
   always_comb begin
      det_total_d = det_total_q;
      if (clr) begin
         det_total_d = '0;
      end else if (det_match && (det_total_q != TOT_MAX)) begin
         det_total_d = det_total_q + TOT_W'(1);
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         data_q      <= '0;
         det_total_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         data_q      <= data_d;
         det_total_q <= det_total_d;
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_count = word_cnt_q;
   assign det_total   = det_total_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
